// File: rtl/lcd_line_packer_pkg.sv
// Shared defaults and state encoding for the LCD line packer.
// The defaults match the SPI screen driver's line format.
package lcd_line_packer_pkg;

  localparam int LINE_BITS_D       = 256;
  localparam int BYTE_W_D          = 8;
  localparam int LINES_PER_FRAME_D = 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } pack_state_e;

  // Counter width that stays legal (>= 1 bit) for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_line_packer_line_reg.sv
// Output slot: holds the line currently offered to the screen.
// Held stable until the screen takes it; a load in the same cycle
// as a consume replaces the line with no gap in bufferDA.
module lcd_line_packer_line_reg #(
  parameter int LINE_BITS = 256,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic [IDX_W-1:0]     idx_in,
  input  logic                 rtr,
  output logic [LINE_BITS-1:0] buffer,
  output logic                 buffer_da,
  output logic [IDX_W-1:0]     line_idx
);

  // Load a new line, or drop valid once the screen has taken the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      buffer    <= '0;
      buffer_da <= 1'b0;
      line_idx  <= '0;
    end else if (load) begin
      buffer    <= line_in;
      buffer_da <= 1'b1;
      line_idx  <= idx_in;
    end else if (buffer_da && rtr) begin
      buffer_da <= 1'b0;
    end
  end

endmodule

// File: rtl/lcd_line_packer.sv
// Packs a byte stream MSB-first into display lines and hands each
// completed line to the screen through a double-buffered output slot.
// An accepted start-of-frame byte restarts the line and the line index.
module lcd_line_packer
  import lcd_line_packer_pkg::*;
#(
  parameter int LINE_BITS       = LINE_BITS_D,
  parameter int BYTE_W          = BYTE_W_D,
  parameter int LINES_PER_FRAME = LINES_PER_FRAME_D
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [BYTE_W-1:0]                     in_data,
  input  logic                                  in_valid,
  input  logic                                  in_sof,
  output logic                                  in_ready,
  output logic [LINE_BITS-1:0]                  buffer,
  output logic                                  bufferDA,
  input  logic                                  bufferRtR,
  output logic [cnt_w(LINES_PER_FRAME)-1:0]     line_idx,
  output logic                                  sof_drop
);

  localparam int N     = LINE_BITS / BYTE_W;
  localparam int CNT_W = cnt_w(N);
  localparam int IDX_W = cnt_w(LINES_PER_FRAME);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(LINES_PER_FRAME - 1);

  pack_state_e                  state;
  logic                         ready_q;
  logic [CNT_W-1:0]             count;
  logic [IDX_W-1:0]             wr_line;
  // Lane N-1 is the top byte of the line, i.e. byte 0 of the stream.
  logic [N-1:0][BYTE_W-1:0]     asm_q;
  logic                         accept;
  logic                         sof_acc;
  logic [CNT_W-1:0]             wr_ptr;
  logic                         load;

  // Ready is held low for the whole reset cycle, then follows the FSM.
  assign in_ready = ready_q & ~reset;
  assign accept   = in_valid & in_ready;
  assign sof_acc  = accept & in_sof;
  assign wr_ptr   = sof_acc ? '0 : count;
  assign load     = (state == ST_FULL) && (!bufferDA || bufferRtR);

  // Assembly register: write the accepted byte into its lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (accept && wr_ptr == CNT_W'(k)) asm_q[N-1-k] <= in_data;
      end
    end
  end

  // Assembly FSM: byte counting, frame resync and hand-off to the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FILL;
      ready_q  <= 1'b1;
      count    <= '0;
      wr_line  <= '0;
      sof_drop <= 1'b0;
    end else begin
      sof_drop <= 1'b0;
      case (state)
        ST_FILL: begin
          if (sof_acc) begin
            count    <= CNT_W'(1);
            wr_line  <= '0;
            sof_drop <= (count != '0);
          end else if (accept) begin
            if (count == LAST_BYTE) begin
              count   <= '0;
              state   <= ST_FULL;
              ready_q <= 1'b0;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        ST_FULL: begin
          if (load) begin
            state   <= ST_FILL;
            ready_q <= 1'b1;
            wr_line <= (wr_line == LAST_LINE) ? '0 : wr_line + IDX_W'(1);
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  lcd_line_packer_line_reg #(
    .LINE_BITS (LINE_BITS),
    .IDX_W     (IDX_W)
  ) u_line_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .line_in   (asm_q),
    .idx_in    (wr_line),
    .rtr       (bufferRtR),
    .buffer    (buffer),
    .buffer_da (bufferDA),
    .line_idx  (line_idx)
  );

endmodule

// File: tb/tb_lcd_line_packer.sv
// Directed bench for lcd_line_packer with default parameters.
module tb_lcd_line_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_sof;
  logic         in_ready;
  logic [255:0] buffer;
  logic         bufferDA;
  logic         bufferRtR;
  logic [2:0]   line_idx;
  logic         sof_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int sof_cnt  = 0;

  logic [255:0] got_line[$];
  logic [2:0]   got_idx[$];

  lcd_line_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .buffer    (buffer),
    .bufferDA  (bufferDA),
    .bufferRtR (bufferRtR),
    .line_idx  (line_idx),
    .sof_drop  (sof_drop)
  );

  always #5 clk = ~clk;

  // Record every completed transfer and every sof_drop pulse.
  always @(negedge clk) begin
    if (bufferDA && bufferRtR) begin
      got_line.push_back(buffer);
      got_idx.push_back(line_idx);
    end
    if (sof_drop) sof_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one byte and return just after the edge that accepted it.
  task automatic send(input logic [7:0] d, input logic sof);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    while (!in_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (!in_ready) check("send_timeout", 256'(in_ready), 256'(1));
    tick(1);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  function automatic logic [255:0] mk_line(input logic [7:0] base);
    logic [255:0] l;
    for (int k = 0; k < 32; k++) l[255-8*k -: 8] = base + 8'(k);
    return l;
  endfunction

  task automatic send_line(input logic [7:0] base);
    for (int k = 0; k < 32; k++) send(base + 8'(k), 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_da",       256'(bufferDA), 256'(0));
    check("rst_buffer",   buffer,         256'(0));
    check("rst_line_idx", 256'(line_idx), 256'(0));
    check("rst_sof_drop", 256'(sof_drop), 256'(0));
    reset = 1'b0;
    #1;
    check("rst_ready_after", 256'(in_ready), 256'(1));
  endtask

  initial begin
    logic [255:0] l1, l2, exp;
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0; bufferRtR = 1'b0;
    tick(2);
    do_reset();

    // Single line, screen not ready.
    l1 = mk_line(8'h00);
    send_line(8'h00);
    check("single_da_t1",     256'(bufferDA), 256'(0));
    check("single_ready_t1",  256'(in_ready), 256'(0));
    tick(1);
    check("single_da_t2",     256'(bufferDA), 256'(1));
    check("single_first",     256'(buffer[255:248]), 256'(8'h00));
    check("single_last",      256'(buffer[7:0]),     256'(8'h1F));
    check("single_line",      buffer,         l1);
    check("single_idx",       256'(line_idx), 256'(0));
    check("single_ready_t2",  256'(in_ready), 256'(1));

    // Back-pressure: second line waits in assembly.
    l2 = mk_line(8'h20);
    send_line(8'h20);
    tick(3);
    check("bp_ready",  256'(in_ready), 256'(0));
    check("bp_da",     256'(bufferDA), 256'(1));
    check("bp_hold",   buffer,         l1);
    check("bp_idx",    256'(line_idx), 256'(0));
    bufferRtR = 1'b1;
    tick(1);
    bufferRtR = 1'b0;
    check("bp_load_line", buffer,         l2);
    check("bp_load_idx",  256'(line_idx), 256'(1));
    check("bp_load_da",   256'(bufferDA), 256'(1));
    bufferRtR = 1'b1;
    tick(1);
    bufferRtR = 1'b0;
    check("bp_drain_da",   256'(bufferDA), 256'(0));
    check("bp_drain_hold", buffer,         l2);
    check("bp_drain_rdy",  256'(in_ready), 256'(1));

    // Wrap: nine lines streamed into an always-ready screen.
    do_reset();
    bufferRtR = 1'b1;
    tick(1);
    got_line.delete(); got_idx.delete();
    for (int l = 0; l < 9; l++) send_line(8'(l * 40));
    tick(4);
    check("wrap_count", 256'(got_line.size()), 256'(9));
    for (int l = 0; l < 9 && l < got_line.size(); l++) begin
      check($sformatf("wrap_idx%0d", l),  256'(got_idx[l]), 256'(l % 8));
      check($sformatf("wrap_line%0d", l), got_line[l],      mk_line(8'(l * 40)));
    end

    // SOF resync after a 10-byte partial line; idle SOF must be ignored.
    got_line.delete(); got_idx.delete();
    sof_cnt = 0;
    for (int k = 0; k < 10; k++) send(8'hC0 + 8'(k), 1'b0);
    in_sof = 1'b1;
    tick(2);
    in_sof = 1'b0;
    check("sof_idle_nodrop", 256'(sof_cnt), 256'(0));
    send(8'hAA, 1'b1);
    exp = '0;
    exp[255:248] = 8'hAA;
    for (int k = 1; k < 32; k++) begin
      send(8'h50 + 8'(k), 1'b0);
      exp[255-8*k -: 8] = 8'h50 + 8'(k);
    end
    tick(4);
    check("sof_drop_once", 256'(sof_cnt),         256'(1));
    check("sof_count",     256'(got_line.size()), 256'(1));
    if (got_line.size() > 0) begin
      check("sof_line", got_line[0],      exp);
      check("sof_idx",  256'(got_idx[0]), 256'(0));
    end

    // Reset mid-operation: line on the slot plus 12 assembled bytes.
    bufferRtR = 1'b0;
    send_line(8'h80);
    for (int k = 0; k < 12; k++) send(8'hF0 + 8'(k), 1'b0);
    check("mid_da_before", 256'(bufferDA), 256'(1));
    do_reset();
    got_line.delete(); got_idx.delete();
    bufferRtR = 1'b1;
    send_line(8'h33);
    tick(6);
    check("mid_count", 256'(got_line.size()), 256'(1));
    if (got_line.size() > 0) begin
      check("mid_line", got_line[0],      mk_line(8'h33));
      check("mid_idx",  256'(got_idx[0]), 256'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_line_packer.md
Name: lcd_line_packer

Overview:
- Upstream feeder for the SPI LCD screen driver: packs a byte stream (pattern generator, UART, LFSR source) into 256-bit display lines.
- Presents each completed line on the screen's `buffer` / `bufferDA` / `bufferRtR` handshake.
- Double-buffered, so the next line assembles while the screen shifts out the current one.
- Tracks line index within a frame and resynchronises on start-of-frame.

Parameters:
- LINE_BITS, 256, width of one display line; must be a multiple of BYTE_W.
- BYTE_W, 8, input word width.
- LINES_PER_FRAME, 8, lines per frame; line index wraps after LINES_PER_FRAME-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  BYTE_W  input byte.
- in_valid  input  1  in_data valid.
- in_sof  input  1  qualifies in_data as first byte of a frame.
- in_ready  output  1  packer accepts a byte this cycle.
- buffer  output  LINE_BITS  completed line to screen.
- bufferDA  output  1  buffer holds a valid line.
- bufferRtR  input  1  screen ready to receive.
- line_idx  output  clog2(LINES_PER_FRAME)  line number of line on buffer.
- sof_drop  output  1  one-cycle pulse: partial line discarded by in_sof.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values:
  - in_ready=0 during reset, 1 on the first cycle after.
  - buffer=0, bufferDA=0, line_idx=0, sof_drop=0.
  - Assembly register 0, byte count 0, write line counter 0.
  - Reset mid-line or mid-handshake discards everything; no line is presented afterwards until a fresh one is complete.
- Accept: byte accepted when in_valid && in_ready. Byte k of a line (k=0..N-1, N=LINE_BITS/BYTE_W=32) lands at asm[LINE_BITS-1-k*BYTE_W -: BYTE_W], i.e. MSB-first; byte 0 is the first bit shifted out.
- Assembly FSM:
  - FILL: in_ready=1; count increments per accepted byte. Accepting byte N-1 goes to FULL next cycle, count to 0.
  - FULL: in_ready=0. If bufferDA==0 or (bufferDA && bufferRtR) this cycle: next cycle buffer<=asm, bufferDA<=1, line_idx<=write line counter, write counter increments (wraps LINES_PER_FRAME-1 -> 0), back to FILL. Otherwise stay in FULL.
- Latency:
  - Last byte accepted at cycle T -> bufferDA=1 and buffer valid at T+2 when the output slot is free.
  - Transfer to screen completes in a cycle where bufferDA && bufferRtR. If no new line loads that cycle, bufferDA drops to 0 next cycle and buffer holds its value.
  - A simultaneous consume plus FULL loads the new line with no DA gap.
- Output stability: buffer and line_idx are stable while bufferDA=1 and bufferRtR=0.
- Start of frame:
  - An accepted byte with in_sof=1 is written as byte 0 and count becomes 1.
  - Write line counter forced to 0, so that line carries line_idx=0.
  - If count was nonzero, the partial line is discarded and sof_drop pulses the next cycle.
  - in_sof while in FULL has no effect: in_ready=0, so the byte is not accepted.
  - in_sof with in_valid=0 is ignored.
- No overflow is possible: the source is back-pressured by in_ready. Throughput is at most one line per N+1 cycles.

Decomposition:
- Shared include `lcd_defs.vh` holds LINE_BITS, BYTE_W, LINES_PER_FRAME defaults and FSM state encodings (FILL=0, FULL=1), so they are common with the screen driver.
- Sub-module: none needed beyond an optional `line_reg` holding the output slot. The block stays one module of roughly 150 lines.

Test Plan:
- Single line: after reset, feed bytes 0x00..0x1F back-to-back with bufferRtR=0. Required: bufferDA=1 two cycles after the last accept; buffer[255:248]=0x00 and buffer[7:0]=0x1F; line_idx=0; in_ready=1 again.
- Back-pressure: keep bufferRtR=0 and feed 64 bytes. Required:
  - The second line stays in FULL with in_ready=0 and buffer unchanged.
  - Raising bufferRtR for one cycle loads line 2 the next cycle with line_idx=1 and bufferDA held high.
- Wrap: stream 9 lines with bufferRtR=1. Required: line_idx sequence 0..7 then 0.
- SOF resync: feed 10 bytes, then a byte 0xAA with in_sof=1, then 31 bytes. Required: sof_drop pulses once; presented line starts with 0xAA; line_idx=0.
- Reset mid-operation:
  - Assert reset while bufferDA=1 and 12 bytes are assembled. Required: bufferDA=0, buffer=0, line_idx=0 the next cycle.
  - Then feed 32 fresh bytes. Required: exactly one line is presented, containing only the fresh bytes.
- Integration: drive the screen driver (10,10 params) from an LFSR byte source. Required: every bufferDA && bufferRtR cycle transfers a line identical to the 32 source bytes in order, with no drops or duplicates over 4096 cycles.
